s_p_frame_ctrl: RTL and testbench
=================================

// Module: s_p_frame_ctrl
// PURPOSE
//  Framing and capture sequencer for the serial-to-parallel converter.
//  - Watches the same serial stream D as the converter and hunts for a sync word.
//  - After sync it pulses the converter latch enable once per C_BITS_OUT bits.
//  - Registers the converter's parallel output and hands it downstream on VALID/READY.
//  - Returns to hunting after C_FRAME_WORDS words.
// PARAMETERS
//  C_BITS_OUT     8      converter word width; must be >= 2
//  C_SYNC_BITS    8      sync word width
//  C_SYNC_PATTERN 8'hA5  sync word; first-received bit is the MSB
//  C_FRAME_WORDS  4      data words per frame after sync; must be >= 1
// PORTS
//  CK          in   1            clock; rising edge
//  RST         in   1            reset; synchronous, active-low
//  EN          in   1            1 = hunt/receive allowed; 0 = forced to HUNT
//  D           in   1            serial bit; also drives the converter's D
//  P_IN        in   C_BITS_OUT   converter parallel Q; [0] = newest bit
//  CAP_EN      out  1            converter latch enable; one-cycle pulse
//  DATA        out  C_BITS_OUT   captured word
//  VALID       out  1            DATA holds an unconsumed word
//  READY       in   1            downstream accepts DATA when VALID & READY
//  LOCKED      out  1            1 while in LOCK
//  FRAME_DONE  out  1            one-cycle pulse at capture of the last word in a frame
//  OVERFLOW    out  1            sticky; a word was dropped
//  CLR_OVF     in   1            synchronous clear of OVERFLOW
// BEHAVIOUR
//  Reset (RST=0 at edge):
//   - State HUNT; fill_cnt, bit_cnt, word_cnt and sync_sr cleared.
//   - All outputs 0, including DATA.
//   - Any word in flight is discarded.
//  HUNT:
//   - Each edge: sync_sr <= {sync_sr[C_SYNC_BITS-2:0], D}.
//   - fill_cnt counts up to C_SYNC_BITS and saturates.
//   - Go to LOCK on the edge where fill_cnt >= C_SYNC_BITS-1 and {sync_sr[C_SYNC_BITS-2:0], D} == C_SYNC_PATTERN.
//   - Entering LOCK clears bit_cnt and word_cnt.
//  LOCK:
//   - bit_cnt increments on each edge and wraps at C_BITS_OUT-1 -> 0.
//   - The edge that samples the C_BITS_OUT-th data bit (bit_cnt == C_BITS_OUT-1) sets CAP_EN=1 for the next cycle only.
//   - Words are back to back, so CAP_EN pulses every C_BITS_OUT cycles.
//  Capture (edge at the end of the CAP_EN cycle):
//   - DATA <= P_IN (pre-edge value) and VALID <= 1, if (!VALID || READY).
//   - Otherwise the word is dropped, DATA/VALID are unchanged, and OVERFLOW <= 1.
//   - word_cnt increments on every capture edge, including dropped words.
//   - Latency: last data bit sampled at edge e; DATA/VALID updated at edge e+1.
//  Handshake:
//   - VALID clears on an edge with VALID & READY and no capture.
//   - Capture together with READY: the new word replaces the old, VALID stays 1, no overflow.
//   - DATA is stable while VALID & !READY.
//  Frame end:
//   - The capture edge where word_cnt == C_FRAME_WORDS-1 pulses FRAME_DONE.
//   - The same edge moves the FSM to HUNT and clears fill_cnt, so sync cannot match on tail bits.
//  EN=0 at edge:
//   - HUNT, counters cleared, any pending CAP_EN cleared; no capture.
//   - DATA/VALID/OVERFLOW are held.
//  OVERFLOW: CLR_OVF clears it. CLR_OVF and a drop on the same edge leave OVERFLOW=1.
//  LOCKED == (state == LOCK), registered.
// STRUCTURE
//  - s_p_pkg: state enum {HUNT, LOCK} and the default parameter constants.
//  - Sub-module s_p_sync_detect: sync_sr, fill_cnt, and a combinational match output.
//  - Top holds the FSM, bit/word counters and the output/handshake register.
// TESTING (C_BITS_OUT=8, sync 8'hA5, C_FRAME_WORDS=2; bench models the converter)
//  - Sync then 8'h3C, 8'hC3, READY=1 -> CAP_EN at cycles +8/+16 after sync; DATA=3C then C3; FRAME_DONE on 2nd capture; LOCKED=0 after.
//  - Bits 8'hA5 with fill_cnt=3 after reset -> no lock; next full A5 -> lock.
//  - READY=0 across two words -> DATA=first word held, OVERFLOW=1; CLR_OVF -> 0.
//  - READY=1 in the capture cycle while VALID=1 -> DATA replaced, OVERFLOW stays 0.
//  - RST=0 mid-word (bit_cnt=5) -> all outputs 0, HUNT; no CAP_EN until new sync + 8 bits.
//  - EN=0 for 1 cycle mid-frame -> HUNT, no capture; relock after re-sent sync.

Source files
------------

// File: rtl/s_p_pkg.sv
// Shared constants for the serial-to-parallel framing sequencer.
// Holds the default parameter set, the FSM state codes and a counter-width helper.
package s_p_pkg;

    localparam int unsigned DEF_BITS_OUT     = 8;
    localparam int unsigned DEF_SYNC_BITS    = 8;
    localparam logic [7:0]  DEF_SYNC_PATTERN = 8'hA5;
    localparam int unsigned DEF_FRAME_WORDS  = 4;

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Width of a counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s_p_sync_detect.sv
// Sync-word hunter: shifts the serial stream and flags a match once enough
// bits have been collected since the last clear.
module s_p_sync_detect
    import s_p_pkg::*;
#(
    parameter int unsigned              C_SYNC_BITS    = DEF_SYNC_BITS,
    parameter logic [C_SYNC_BITS-1:0]   C_SYNC_PATTERN = C_SYNC_BITS'(DEF_SYNC_PATTERN)
) (
    input  logic ck_i,
    input  logic rst_i,
    input  logic hunt_i,
    input  logic d_i,
    output logic match_o
);

    localparam int unsigned           FILL_W   = $clog2(C_SYNC_BITS + 1);
    localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(C_SYNC_BITS);
    localparam logic [FILL_W-1:0]     FILL_ARM = FILL_W'(C_SYNC_BITS - 1);

    logic [C_SYNC_BITS-1:0] sync_sr_q, sync_sr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [C_SYNC_BITS-1:0] window;

    // fill_cnt gates the match so stale shift-register contents never count.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        window    = {sync_sr_q[C_SYNC_BITS-2:0], d_i};
        sync_sr_d = window;
        fill_d    = '0;
        if (hunt_i) begin
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
        end
        match_o = hunt_i && (fill_q >= FILL_ARM) && (window == C_SYNC_PATTERN);
    end

    // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge ck_i) begin
        if (!rst_i) begin
            sync_sr_q <= '0;
            fill_q    <= '0;
        end else begin
            sync_sr_q <= sync_sr_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/s_p_frame_ctrl.sv
// Framing and capture sequencer: hunts for sync, pulses the converter latch
// once per word, and holds captured words for a VALID/READY consumer.
module s_p_frame_ctrl
    import s_p_pkg::*;
#(
    parameter int unsigned            C_BITS_OUT     = DEF_BITS_OUT,
    parameter int unsigned            C_SYNC_BITS    = DEF_SYNC_BITS,
    parameter logic [C_SYNC_BITS-1:0] C_SYNC_PATTERN = C_SYNC_BITS'(DEF_SYNC_PATTERN),
    parameter int unsigned            C_FRAME_WORDS  = DEF_FRAME_WORDS
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  D,
    input  logic [C_BITS_OUT-1:0] P_IN,
    output logic                  CAP_EN,
    output logic [C_BITS_OUT-1:0] DATA,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  LOCKED,
    output logic                  FRAME_DONE,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF
);

    localparam int unsigned        BIT_W     = cnt_width(C_BITS_OUT);
    localparam int unsigned        WORD_W    = cnt_width(C_FRAME_WORDS);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(C_BITS_OUT - 1);
    localparam logic [WORD_W-1:0]  WORD_LAST = WORD_W'(C_FRAME_WORDS - 1);

    logic [0:0]            state_q, state_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  cap_en_q, cap_en_d;
    logic [C_BITS_OUT-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic hunting;
    logic sync_match;
    logic capture;
    logic accept;
    logic frame_end;

    assign hunting = EN && (state_q == ST_HUNT);

    s_p_sync_detect #(
        .C_SYNC_BITS    (C_SYNC_BITS),
        .C_SYNC_PATTERN (C_SYNC_PATTERN)
    ) u_sync (
        .ck_i    (CK),
        .rst_i   (RST),
        .hunt_i  (hunting),
        .d_i     (D),
        .match_o (sync_match)
    );

    always_comb begin
        capture   = EN && cap_en_q;
        accept    = capture && (!valid_q || READY);
        frame_end = capture && (word_q == WORD_LAST);

        state_d  = state_q;
        bit_d    = bit_q;
        word_d   = word_q;
        cap_en_d = 1'b0;
        done_d   = 1'b0;
        data_d   = data_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;

        if (!EN) begin
            // Disabled: abandon any frame in progress but keep the output register intact.
            state_d = ST_HUNT;
            bit_d   = '0;
            word_d  = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_match) begin
                        state_d = ST_LOCK;
                        bit_d   = '0;
                        word_d  = '0;
                    end
                end
                default: begin
                    bit_d    = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
                    cap_en_d = (bit_q == BIT_LAST);
                    if (capture) begin
                        word_d = word_q + WORD_W'(1);
                    end
                    if (frame_end) begin
                        state_d  = ST_HUNT;
                        bit_d    = '0;
                        word_d   = '0;
                        cap_en_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            endcase

            // A capture always wins over a plain handshake; a blocked capture is dropped.
            if (accept) begin
                data_d  = P_IN;
                valid_d = 1'b1;
            end else if (!capture && valid_q && READY) begin
                valid_d = 1'b0;
            end

            if (capture && !accept) begin
                ovf_d = 1'b1;
            end else if (CLR_OVF) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (!RST) begin
            state_q  <= ST_HUNT;
            bit_q    <= '0;
            word_q   <= '0;
            cap_en_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            cap_en_q <= cap_en_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign CAP_EN     = cap_en_q;
    assign DATA       = data_q;
    assign VALID      = valid_q;
    assign LOCKED     = (state_q == ST_LOCK);
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_s_p_frame_ctrl.sv
// Bench for s_p_frame_ctrl: directed framing scenarios plus randomized traffic,
// all checked every cycle against a timeline-based reference model.
module tb_s_p_frame_ctrl;

    localparam int unsigned BW   = 8;
    localparam int unsigned FW   = 2;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic          CK = 1'b0;
    logic          RST, EN, D, READY, CLR_OVF;
    logic [BW-1:0] P_IN;
    logic          CAP_EN, VALID, LOCKED, FRAME_DONE, OVERFLOW;
    logic [BW-1:0] DATA;

    int n_vec = 0;
    int n_err = 0;

    always #5 CK = ~CK;

    s_p_frame_ctrl #(
        .C_BITS_OUT     (BW),
        .C_SYNC_BITS    (8),
        .C_SYNC_PATTERN (SYNC),
        .C_FRAME_WORDS  (FW)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .EN         (EN),
        .D          (D),
        .P_IN       (P_IN),
        .CAP_EN     (CAP_EN),
        .DATA       (DATA),
        .VALID      (VALID),
        .READY      (READY),
        .LOCKED     (LOCKED),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW),
        .CLR_OVF    (CLR_OVF)
    );

    // Serial-to-parallel converter: newest bit lands in [0].
    logic [BW-1:0] conv_q = '0;
    always @(posedge CK) conv_q <= {conv_q[BW-2:0], D};
    assign P_IN = conv_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks edges since lock; captures fall at lock+9, +17, ...
    bit            m_live   = 1'b0;
    bit            m_locked = 1'b0;
    int            m_since  = 0;
    int            m_hunt   = 0;
    logic [7:0]    m_hist   = '0;
    logic [BW-1:0] m_data   = '0;
    bit            m_valid  = 1'b0;
    bit            m_ovf    = 1'b0;
    bit            m_cap    = 1'b0;
    bit            m_done   = 1'b0;

    task automatic model_step();
        bit cap, acc;
        cap    = 1'b0;
        m_live = 1'b1;
        m_hist = {m_hist[6:0], D};
        if (!RST) begin
            m_locked = 1'b0; m_hunt = 0; m_data = '0; m_valid = 1'b0;
            m_ovf = 1'b0; m_cap = 1'b0; m_done = 1'b0;
        end else if (!EN) begin
            m_locked = 1'b0; m_hunt = 0; m_cap = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            m_cap  = 1'b0;
            if (m_locked) begin
                m_since++;
                cap = (m_since > 1) && (m_since % BW == 1);
                if (cap && ((m_since - 1) / BW == FW)) begin
                    m_done = 1'b1; m_locked = 1'b0; m_hunt = 0;
                end else if (m_since % BW == 0) begin
                    m_cap = 1'b1;
                end
            end else begin
                if (m_hunt < 8) m_hunt++;
                if (m_hunt == 8 && m_hist == SYNC) begin
                    m_locked = 1'b1; m_since = 0;
                end
            end
            acc = cap && (!m_valid || READY);
            if (acc) begin
                m_data = P_IN; m_valid = 1'b1;
            end else if (!cap && m_valid && READY) begin
                m_valid = 1'b0;
            end
            if (cap && !acc) m_ovf = 1'b1;
            else if (CLR_OVF) m_ovf = 1'b0;
        end
    endtask

    always @(negedge CK) begin
        if (m_live) begin
            check("cap_en",     CAP_EN,     m_cap);
            check("locked",     LOCKED,     m_locked);
            check("frame_done", FRAME_DONE, m_done);
            check("valid",      VALID,      m_valid);
            check("data",       DATA,       m_data);
            check("overflow",   OVERFLOW,   m_ovf);
        end
    end

    bit rand_ctl = 1'b0;

    task automatic tick();
        @(posedge CK);
        model_step();
        #2;
    endtask

    task automatic send_bit(input logic b);
        D = b;
        if (rand_ctl) begin
            READY   = ($urandom % 4) != 0;
            CLR_OVF = ($urandom % 16) == 0;
            EN      = ($urandom % 64) != 0;
            RST     = ($urandom % 200) != 0;
        end
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        RST = 1'b1;
    endtask

    logic [7:0] w;

    initial begin
        RST = 1'b0; EN = 1'b0; D = 1'b0; READY = 1'b0; CLR_OVF = 1'b0;
        tick();
        tick();
        check("rst_cap_en", CAP_EN, 0);
        check("rst_valid",  VALID,  0);
        check("rst_data",   DATA,   0);
        check("rst_locked", LOCKED, 0);
        RST = 1'b1; EN = 1'b1; READY = 1'b1;

        // Basic frame: two words, ready consumer.
        send_byte(SYNC);
        check("t1_locked", LOCKED, 1);
        send_byte(8'h3C);
        check("t1_cap_en_w0", CAP_EN, 1);
        w = 8'hC3;
        send_bit(w[7]);
        check("t1_data_w0",  DATA,   8'h3C);
        check("t1_valid_w0", VALID,  1);
        check("t1_cap_off",  CAP_EN, 0);
        for (int i = 6; i >= 0; i--) send_bit(w[i]);
        check("t1_cap_en_w1", CAP_EN, 1);
        send_bit(1'b0);
        check("t1_data_w1",     DATA,       8'hC3);
        check("t1_frame_done",  FRAME_DONE, 1);
        check("t1_unlocked",    LOCKED,     0);

        // Tail bits form A5 with only four hunt bits collected: must not lock.
        do_reset();
        send_byte(SYNC);
        send_byte(8'h77);
        send_byte(8'h05);
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t2_no_lock_tail", LOCKED, 0);
        send_byte(SYNC);
        check("t2_lock_full", LOCKED, 1);

        // Stalled consumer across two words: second word dropped.
        do_reset();
        READY = 1'b0;
        send_byte(SYNC);
        send_byte(8'h11);
        send_byte(8'h22);
        send_bit(1'b0);
        check("t3_data_held", DATA,     8'h11);
        check("t3_valid",     VALID,    1);
        check("t3_overflow",  OVERFLOW, 1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("t3_ovf_clear", OVERFLOW, 0);

        // Consumer ready exactly in the capture cycle: word replaced, no overflow.
        do_reset();
        READY = 1'b0;
        send_byte(SYNC);
        send_byte(8'h11);
        send_byte(8'h22);
        check("t4_valid_pre", VALID, 1);
        READY = 1'b1;
        send_bit(1'b0);
        check("t4_data_new", DATA,     8'h22);
        check("t4_no_ovf",   OVERFLOW, 0);

        // Reset mid-word clears everything; no latch pulse until a fresh sync.
        do_reset();
        READY = 1'b0;
        send_byte(SYNC);
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        check("t5_data_pre", DATA, 8'h5A);
        RST = 1'b0;
        tick();
        check("t5_rst_data",   DATA,   0);
        check("t5_rst_valid",  VALID,  0);
        check("t5_rst_locked", LOCKED, 0);
        RST = 1'b1; READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b0);
            check("t5_no_cap", CAP_EN, 0);
        end
        send_byte(SYNC);
        send_byte(8'h81);
        check("t5_cap_after_sync", CAP_EN, 1);

        // One disabled cycle mid-frame forces HUNT; re-sent sync relocks.
        do_reset();
        send_byte(SYNC);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        EN = 1'b0;
        tick();
        EN = 1'b1;
        check("t6_unlocked", LOCKED, 0);
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        check("t6_no_cap", CAP_EN, 0);
        send_byte(SYNC);
        check("t6_relock", LOCKED, 1);
        send_byte(8'h96);
        send_bit(1'b0);
        check("t6_data", DATA, 8'h96);

        // Randomized traffic with injected sync words and random control lines.
        rand_ctl = 1'b1;
        for (int it = 0; it < 300; it++) begin
            int nb;
            if ($urandom_range(0, 9) < 4) send_byte(SYNC);
            nb = $urandom_range(4, 20);
            for (int j = 0; j < nb; j++) send_bit(1'($urandom));
        end
        rand_ctl = 1'b0;
        RST = 1'b1; EN = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
